// File: rtl/pc_ras_unit.sv
// pc_ras_unit: next-pc generation (seq/branch/jump) with a circular return-address stack
// for call/return; overflow drops the oldest entry, underflow falls back to pc+INC.
module pc_ras_unit #(
   parameter int PC_W      = 10,
   parameter int DATA_W    = 32,
   parameter int INSTR_W   = 16,
   parameter int OFFS_W    = 10,
   parameter int INC       = 1,
   parameter int RAS_DEPTH = 4,
   parameter int RESET_PC  = 0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic [2:0]         pc_mux,
   input  logic               taken,
   input  logic [DATA_W-1:0]  pc_rd,
   input  logic [DATA_W-1:0]  result,
   input  logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_inc,
   output logic               ras_empty,
   output logic               ras_full,
   output logic               ras_ovf,
   output logic               ras_udf
);
   localparam int AW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   logic [PC_W-1:0]        ras [RAS_DEPTH];
   logic [AW-1:0]          top;
   logic [CW-1:0]          cnt;
   logic [PC_W+OFFS_W-1:0] off_x;
   logic [PC_W-1:0]        off, pc_nxt;
   logic                   push, pop, unused;
   assign unused    = ^{pc_rd, result, instr};
   assign pc_inc    = pc + PC_W'(INC);
   assign off_x     = {{PC_W{instr[OFFS_W-1]}}, instr[OFFS_W-1:0]};
   assign off       = off_x[PC_W-1:0];
   assign push      = !stall && (pc_mux == 3'b100 || pc_mux == 3'b110);
   assign pop       = !stall && pc_mux == 3'b101;
   assign ras_empty = cnt == '0;
   assign ras_full  = cnt == CW'(RAS_DEPTH);
   always_comb
      case (pc_mux)
         3'b001:         pc_nxt = taken ? pc + off : pc_inc;
         3'b010, 3'b100: pc_nxt = pc_rd[PC_W-1:0];
         3'b011:         pc_nxt = result[PC_W-1:0];
         3'b101:         pc_nxt = ras_empty ? pc_inc : ras[top];
         3'b110:         pc_nxt = pc + off;
         default:        pc_nxt = pc_inc;
      endcase
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pc      <= PC_W'(RESET_PC);
         top     <= '0;
         cnt     <= '0;
         ras_ovf <= 1'b0;
         ras_udf <= 1'b0;
      end else if (!stall) begin
         pc <= pc_nxt;
         if (push) begin
            top <= top + AW'(1);
            if (ras_full) ras_ovf <= 1'b1;
            else cnt <= cnt + CW'(1);
         end else if (pop) begin
            if (ras_empty) ras_udf <= 1'b1;
            else begin
               top <= top - AW'(1);
               cnt <= cnt - CW'(1);
            end
         end
      end
   // stack contents need no reset; a full stack simply overwrites the oldest slot
   always_ff @(posedge clk)
      if (push && !reset) ras[top + AW'(1)] <= pc_inc;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed test-plan checks plus randomized stimulus compared every
// cycle against a queue-based stack model of the next-pc rules.
module tb_pc_ras_unit;
   localparam int PC_W = 10, DEPTH = 4, MASK = (1 << PC_W) - 1;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, taken = 1'b0;
   logic [2:0]  pc_mux = 3'b000;
   logic [31:0] pc_rd = '0, result = '0;
   logic [15:0] instr = '0;
   logic [9:0]  pc, pc_inc;
   logic        ras_empty, ras_full, ras_ovf, ras_udf;
   int          n_pass = 0, n_tot = 0;
   int          m_pc = 0, stk[$];
   bit          m_ovf = 0, m_udf = 0, chk_en = 0;

   pc_ras_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_mux(pc_mux), .taken(taken),
      .pc_rd(pc_rd), .result(result), .instr(instr), .pc(pc), .pc_inc(pc_inc),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int offs(input logic [15:0] ins);
      int o = int'(ins[9:0]);
      return o >= 512 ? o - 1024 : o;
   endfunction

   task automatic model_reset();
      m_pc = 0; stk.delete(); m_ovf = 0; m_udf = 0;
   endtask

   // model of one clock edge, expressed as a bounded LIFO of return addresses
   task automatic model_step();
      int inc = (m_pc + 1) & MASK;
      if (stall) return;
      case (pc_mux)
         3'd1: m_pc = taken ? (m_pc + offs(instr)) & MASK : inc;
         3'd2: m_pc = int'(pc_rd) & MASK;
         3'd3: m_pc = int'(result) & MASK;
         3'd4, 3'd6: begin
            if (stk.size() == DEPTH) begin void'(stk.pop_front()); m_ovf = 1; end
            stk.push_back(inc);
            m_pc = pc_mux == 3'd4 ? int'(pc_rd) & MASK : (m_pc + offs(instr)) & MASK;
         end
         3'd5: if (stk.size() == 0) begin m_udf = 1; m_pc = inc; end
               else m_pc = stk.pop_back();
         default: m_pc = inc;
      endcase
   endtask

   task automatic step(input logic [2:0] m, input logic s, input logic t,
                       input logic [31:0] rd, input logic [31:0] res, input logic [15:0] ins);
      pc_mux = m; stall = s; taken = t; pc_rd = rd; result = res; instr = ins;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk)
      if (chk_en && !reset) begin
         check("pc", int'(pc), m_pc);
         check("pc_inc", int'(pc_inc), (m_pc + 1) & MASK);
         check("ras_empty", int'(ras_empty), int'(stk.size() == 0));
         check("ras_full", int'(ras_full), int'(stk.size() == DEPTH));
         check("ras_ovf", int'(ras_ovf), int'(m_ovf));
         check("ras_udf", int'(ras_udf), int'(m_udf));
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1;
      check("rst_pc", int'(pc), 0);
      check("rst_empty", int'(ras_empty), 1);
      check("rst_full", int'(ras_full), 0);
      check("rst_flags", int'({ras_ovf, ras_udf}), 0);
      for (int i = 1; i <= 4; i++) begin
         step(3'd0, 0, 0, 0, 0, 0);
         check("seq_pc", int'(pc), i);
      end
      #2 reset = 1'b1; model_reset();
      #1 check("async_rst_pc", int'(pc), 0);
      reset = 1'b0;
      step(3'd2, 0, 0, 5, 0, 0);
      step(3'd1, 0, 1, 0, 0, 16'h03FE);
      check("br_taken", int'(pc), 3);
      step(3'd2, 0, 0, 5, 0, 0);
      step(3'd1, 0, 0, 0, 0, 16'h03FE);
      check("br_not_taken", int'(pc), 6);
      step(3'd3, 0, 0, 0, 1023, 0);
      step(3'd0, 0, 0, 0, 0, 0);
      check("wrap", int'(pc), 0);
      step(3'd3, 0, 0, 0, 32'hFFFF, 0);
      check("trunc", int'(pc), 1023);
      step(3'd2, 0, 0, 10, 0, 0);
      step(3'd4, 0, 0, 200, 0, 0);
      check("call_pc", int'(pc), 200);
      check("call_nonempty", int'(ras_empty), 0);
      step(3'd5, 0, 0, 0, 0, 0);
      check("ret_pc", int'(pc), 11);
      check("ret_empty", int'(ras_empty), 1);
      step(3'd2, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(3'd4, 0, 0, 100 * i, 0, 0);
      check("ovf", int'(ras_ovf), 1);
      check("full", int'(ras_full), 1);
      for (int i = 4; i >= 1; i--) begin
         step(3'd5, 0, 0, 0, 0, 0);
         check("ret_chain", int'(pc), 100 * i + 1);
      end
      step(3'd5, 0, 0, 0, 0, 0);
      check("udf_pc", int'(pc), 102);
      check("udf", int'(ras_udf), 1);
      step(3'd4, 1, 0, 700, 0, 0);
      check("stall_pc", int'(pc), 102);
      check("stall_empty", int'(ras_empty), 1);
      step(3'd4, 0, 0, 700, 0, 0);
      check("unstall_pc", int'(pc), 700);
      step(3'd6, 0, 1, 0, 0, 16'h03FE);
      check("call_rel_pc", int'(pc), 698);
      step(3'd5, 0, 0, 0, 0, 0);
      check("call_rel_ret", int'(pc), 701);
      for (int i = 0; i < 3000; i++) begin
         if (i % 700 == 350) begin
            #2 reset = 1'b1; model_reset();
            #1 reset = 1'b0;
         end
         step(3'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, 1'($urandom),
              $urandom, $urandom, 16'($urandom));
      end
      @(negedge clk);
      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
